ctrl_encoder: RTL and testbench
===============================

CTRL_ENCODER -- requirements
Module: ctrl_encoder

Interface
REQ-001 SHALL have parameter AW, default 8, meaning instruction-memory address width; depth is 2**AW words.
REQ-002 SHALL have ports: Clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  one-cycle pulse that begins a new program image at address 0.
REQ-005 SHALL have ports: stop  in  1  one-cycle pulse that ends the image.
REQ-006 SHALL have ports: in_valid  in  1  control bundle offered; in_ready  out  1  bundle accepted when both high at a rising edge.
REQ-007 SHALL have bundle ports, all inputs: ALUOp 3, isAdd 1, isShift 1, isBranch 1, MemtoReg 1, MemWrite 1, RegWrite 1, operand 6.
REQ-008 SHALL have ports: mem_we  out  1; mem_addr  out  AW; mem_wdata  out  9 (instruction-memory write port).
REQ-009 SHALL have ports: busy  out  1  state is RUN; done  out  1  state is HALT.
REQ-010 SHALL have ports: err  out  1  sticky illegal-bundle flag; err_addr  out  AW  write address current at first illegal bundle.
REQ-011 SHALL have ports: count  out  AW+1  legal words written since start.

Function
REQ-012 SHALL implement states IDLE, RUN and HALT.
REQ-013 Transitions SHALL be: IDLE/HALT -> RUN on start; RUN -> HALT on stop; RUN -> HALT on the edge that accepts the word at address 2**AW-1.
REQ-014 start SHALL take priority over stop and over acceptance in the same cycle; start in RUN restarts the image.
REQ-015 On start edge: write address <= 0, count <= 0, err <= 0, err_addr <= 0.
REQ-016 in_ready SHALL be 1 only when state is RUN and start and stop are both 0.
REQ-017 Legality: a bundle SHALL be legal only if it equals the canonical decode of its ALUOp: RegWrite=1 for all except 011 and 101; isAdd=1 only for 000; isShift=1 only for 001; isBranch=1 only for 011; MemtoReg=1 only for 100; MemWrite=1 only for 101; every other flag 0.
REQ-018 An accepted legal bundle SHALL produce the word {ALUOp, operand} (ALUOp in bits 8:6).
REQ-019 Latency: accepted at edge k -> mem_we=1 with mem_addr and mem_wdata stable for exactly the cycle after edge k; count and write address increment at edge k.
REQ-020 Write address SHALL increment by 1 per legal accept with no wrap; reaching 2**AW-1 forces HALT per REQ-013.
REQ-021 An accepted illegal bundle SHALL produce no write and no increment; err SHALL set; err_addr SHALL capture the write address only if err was 0.
REQ-022 mem_we SHALL be 0 in every cycle not following a legal accept.
REQ-023 A write issued from an accept at the edge before a start or stop SHALL still complete at its original address.
REQ-024 Back-to-back accepts SHALL sustain one word per cycle.
REQ-025 mem_addr and mem_wdata SHALL hold their last values while mem_we=0.

Reset
REQ-026 Reset low SHALL immediately force state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, err=0, err_addr=0, count=0, independent of Clk.
REQ-027 Reset asserted mid-RUN SHALL abort any pending write, with mem_we low during reset; after release the block SHALL stay in IDLE until start.

Verification
REQ-028 Reset release, start, then three legal bundles (ALUOp 000/isAdd/RegWrite/operand 05; 011/isBranch/operand 3F; 101/MemWrite/operand 00) -> writes 0x005@0, 0x0FF@1, 0x140@2, each one cycle after its accept; count=3.
REQ-029 In RUN, ALUOp 010 with isShift=1 -> no mem_we, err=1, err_addr = current address; next legal bundle written at that same address.
REQ-030 AW=2, start, five continuous legal bundles -> four writes @0..3; HALT after fourth accept; in_ready=0 for the fifth; done=1; count=4.
REQ-031 Accept at edge k with stop at edge k+1 -> write for the k accept still occurs; no further accepts; done=1.
REQ-032 start pulse mid-RUN with in_valid held high -> no accept that cycle; next accept writes @0; err and count cleared.
REQ-033 Reset low between an accept and its write cycle -> mem_we stays 0, all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/ctrl_encoder.sv
// ctrl_encoder: packs decoded control bundles into 9-bit words
// and streams them into instruction memory, flagging illegal bundles.
module ctrl_encoder #(
  parameter int AW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          stop,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    ALUOp,
  input  logic          isAdd,
  input  logic          isShift,
  input  logic          isBranch,
  input  logic          MemtoReg,
  input  logic          MemWrite,
  input  logic          RegWrite,
  input  logic [5:0]    operand,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [8:0]    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic [AW:0]   count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [AW-1:0] LAST  = {AW{1'b1}};
  localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   C_ONE = {{AW{1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [AW-1:0] waddr;
  logic [5:0]    canon;
  logic [5:0]    flags;
  logic          legal;
  logic          accept;

  assign flags = {isAdd, isShift, isBranch,
                  MemtoReg, MemWrite, RegWrite};

  // canonical flag set for each ALUOp
  always_comb begin
    canon = 6'b000001;
    unique case (1'b1)
      (ALUOp == 3'd0): canon = 6'b100001;
      (ALUOp == 3'd1): canon = 6'b010001;
      (ALUOp == 3'd3): canon = 6'b001000;
      (ALUOp == 3'd4): canon = 6'b000101;
      (ALUOp == 3'd5): canon = 6'b000010;
      default:         canon = 6'b000001;
    endcase
  end

  assign legal    = (flags == canon);
  assign in_ready = (state == RUN) && !start && !stop;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign done     = (state == HALT);

  // sequencing: state, write address, count and error capture
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      waddr    <= '0;
      count    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else if (start) begin
      state    <= RUN;
      waddr    <= '0;
      count    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else if (stop) begin
      if (state == RUN) state <= HALT;
    end else if (accept) begin
      if (legal) begin
        count <= count + C_ONE;
        if (waddr == LAST) state <= HALT;
        else               waddr <= waddr + A_ONE;
      end else begin
        err <= 1'b1;
        if (!err) err_addr <= waddr;
      end
    end
  end

  // memory write port: one-cycle strobe, address/data hold otherwise
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept && legal;
      if (accept && legal) begin
        mem_addr  <= waddr;
        mem_wdata <= {ALUOp, operand};
      end
    end
  end

endmodule

// File: tb/tb_ctrl_encoder.sv
// tb_ctrl_encoder: directed + random checks of ctrl_encoder
// at AW=8 and AW=2 against a behavioural model.
module tb_ctrl_encoder;

  logic       Clk;
  logic       Reset;
  logic       start, stop, in_valid;
  logic [2:0] ALUOp;
  logic       isAdd, isShift, isBranch;
  logic       MemtoReg, MemWrite, RegWrite;
  logic [5:0] operand;

  logic       d0_rdy, d0_we, d0_busy, d0_done, d0_err;
  logic [7:0] d0_addr, d0_eaddr;
  logic [8:0] d0_wdata;
  logic [8:0] d0_count;

  logic       d1_rdy, d1_we, d1_busy, d1_done, d1_err;
  logic [1:0] d1_addr, d1_eaddr;
  logic [8:0] d1_wdata;
  logic [2:0] d1_count;

  int nvec = 0;
  int nfail = 0;

  int depth [2] = '{256, 4};
  int m_st [2];
  int m_addr [2];
  int m_cnt [2];
  int m_eaddr [2];
  int m_err [2];
  int m_we [2];
  int m_waddr [2];
  int m_wdata [2];

  ctrl_encoder #(.AW(8)) u0 (
    .Clk(Clk), .Reset(Reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(d0_rdy),
    .ALUOp(ALUOp), .isAdd(isAdd), .isShift(isShift),
    .isBranch(isBranch), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .operand(operand),
    .mem_we(d0_we), .mem_addr(d0_addr), .mem_wdata(d0_wdata),
    .busy(d0_busy), .done(d0_done), .err(d0_err),
    .err_addr(d0_eaddr), .count(d0_count)
  );

  ctrl_encoder #(.AW(2)) u1 (
    .Clk(Clk), .Reset(Reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(d1_rdy),
    .ALUOp(ALUOp), .isAdd(isAdd), .isShift(isShift),
    .isBranch(isBranch), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .operand(operand),
    .mem_we(d1_we), .mem_addr(d1_addr), .mem_wdata(d1_wdata),
    .busy(d1_busy), .done(d1_done), .err(d1_err),
    .err_addr(d1_eaddr), .count(d1_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // canonical flag vector {add,shift,branch,m2r,mw,rw}
  function automatic logic [5:0] canon(int op);
    logic [5:0] c;
    c[5] = (op == 0);
    c[4] = (op == 1);
    c[3] = (op == 3);
    c[2] = (op == 4);
    c[1] = (op == 5);
    c[0] = !(op == 3 || op == 5);
    return c;
  endfunction

  function automatic logic [5:0] cur_flags();
    return {isAdd, isShift, isBranch,
            MemtoReg, MemWrite, RegWrite};
  endfunction

  task automatic setb(int op, logic [5:0] f, int opd);
    ALUOp = 3'(op);
    {isAdd, isShift, isBranch, MemtoReg, MemWrite, RegWrite} = f;
    operand = 6'(opd);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_addr[i] = 0; m_cnt[i] = 0;
      m_eaddr[i] = 0; m_err[i] = 0; m_we[i] = 0;
      m_waddr[i] = 0; m_wdata[i] = 0;
    end
  endtask

  function automatic int mrdy(int i);
    return (m_st[i] == 1 && !start && !stop) ? 1 : 0;
  endfunction

  // model of one rising edge (0 idle, 1 run, 2 halt)
  task automatic model_edge();
    int acc;
    int lg;
    lg = (cur_flags() == canon(int'(ALUOp))) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      acc = (in_valid && mrdy(i) == 1) ? 1 : 0;
      m_we[i] = 0;
      if (start) begin
        m_st[i] = 1; m_addr[i] = 0; m_cnt[i] = 0;
        m_err[i] = 0; m_eaddr[i] = 0;
      end else if (stop) begin
        if (m_st[i] == 1) m_st[i] = 2;
      end else if (acc == 1) begin
        if (lg == 1) begin
          m_we[i] = 1;
          m_waddr[i] = m_addr[i];
          m_wdata[i] = int'(ALUOp) * 64 + int'(operand);
          m_cnt[i]++;
          if (m_addr[i] == depth[i] - 1) m_st[i] = 2;
          else m_addr[i]++;
        end else begin
          if (m_err[i] == 0) m_eaddr[i] = m_addr[i];
          m_err[i] = 1;
        end
      end
    end
  endtask

  task automatic chk_rdy();
    chk("i0_ready", 32'(d0_rdy), 32'(mrdy(0)));
    chk("i1_ready", 32'(d1_rdy), 32'(mrdy(1)));
  endtask

  task automatic chk_outs();
    logic [31:0] we, ad, wd, bz, dn, er, ea, ct;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        we = 32'(d0_we); ad = 32'(d0_addr); wd = 32'(d0_wdata);
        bz = 32'(d0_busy); dn = 32'(d0_done); er = 32'(d0_err);
        ea = 32'(d0_eaddr); ct = 32'(d0_count);
      end else begin
        we = 32'(d1_we); ad = 32'(d1_addr); wd = 32'(d1_wdata);
        bz = 32'(d1_busy); dn = 32'(d1_done); er = 32'(d1_err);
        ea = 32'(d1_eaddr); ct = 32'(d1_count);
      end
      chk($sformatf("i%0d_mem_we", i), we, 32'(m_we[i]));
      chk($sformatf("i%0d_mem_addr", i), ad, 32'(m_waddr[i]));
      chk($sformatf("i%0d_mem_wdata", i), wd, 32'(m_wdata[i]));
      chk($sformatf("i%0d_busy", i), bz, 32'(m_st[i] == 1));
      chk($sformatf("i%0d_done", i), dn, 32'(m_st[i] == 2));
      chk($sformatf("i%0d_err", i), er, 32'(m_err[i]));
      chk($sformatf("i%0d_err_addr", i), ea, 32'(m_eaddr[i]));
      chk($sformatf("i%0d_count", i), ct, 32'(m_cnt[i]));
    end
  endtask

  // one clock: inputs already driven at edge+1
  task automatic cyc();
    #1;
    chk_rdy();
    model_edge();
    @(posedge Clk);
    #1;
    chk_outs();
  endtask

  initial begin
    start = 0; stop = 0; in_valid = 0;
    setb(0, 6'b0, 0);
    Reset = 1'b0;
    model_reset();
    #3;
    chk_outs();
    chk_rdy();
    @(posedge Clk);
    #1 Reset = 1'b1;

    // three legal bundles after start
    start = 1; cyc(); start = 0;
    in_valid = 1;
    setb(0, 6'b100001, 5); cyc();
    chk("r28_w0_data", 32'(d0_wdata), 32'h005);
    chk("r28_w0_addr", 32'(d0_addr), 32'h0);
    setb(3, 6'b001000, 63); cyc();
    chk("r28_w1_data", 32'(d0_wdata), 32'h0FF);
    chk("r28_w1_addr", 32'(d0_addr), 32'h1);
    setb(5, 6'b000010, 0); cyc();
    chk("r28_w2_data", 32'(d0_wdata), 32'h140);
    chk("r28_w2_addr", 32'(d0_addr), 32'h2);
    in_valid = 0; cyc();
    chk("r28_count", 32'(d0_count), 32'd3);

    // illegal bundle then legal reuse of the address
    in_valid = 1;
    setb(2, 6'b010001, 7); cyc();
    chk("r29_we", 32'(d0_we), 32'd0);
    chk("r29_err", 32'(d0_err), 32'd1);
    chk("r29_eaddr", 32'(d0_eaddr), 32'd3);
    setb(2, 6'b000001, 9); cyc();
    chk("r29_addr", 32'(d0_addr), 32'd3);
    chk("r29_data", 32'(d0_wdata), 32'h089);

    // accept then stop
    setb(4, 6'b000101, 17); cyc();
    stop = 1; cyc(); stop = 0;
    chk("r31_done", 32'(d0_done), 32'd1);
    cyc();
    chk("r31_count", 32'(d0_count), 32'd5);
    in_valid = 0;

    // restart mid-run with valid held
    start = 1; cyc(); start = 0;
    in_valid = 1;
    setb(1, 6'b010001, 2); cyc();
    setb(6, 6'b100001, 3); cyc();
    setb(7, 6'b000001, 4); start = 1; cyc(); start = 0;
    chk("r32_we", 32'(d0_we), 32'd0);
    chk("r32_err", 32'(d0_err), 32'd0);
    chk("r32_count", 32'(d0_count), 32'd0);
    cyc();
    chk("r32_addr", 32'(d0_addr), 32'd0);
    chk("r32_wdata", 32'(d0_wdata), 32'h1C4);

    // fill the AW=2 image
    in_valid = 0;
    start = 1; cyc(); start = 0;
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      setb(k % 8, canon(k % 8), k + 10);
      cyc();
    end
    chk("r30_done", 32'(d1_done), 32'd1);
    chk("r30_count", 32'(d1_count), 32'd4);
    chk("r30_we", 32'(d1_we), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int op;
      start = ($urandom_range(0, 99) < 3);
      stop = ($urandom_range(0, 99) < 4);
      in_valid = ($urandom_range(0, 99) < 75);
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 80)
        setb(op, canon(op), int'($urandom_range(0, 63)));
      else
        setb(op, 6'($urandom_range(0, 63)),
             int'($urandom_range(0, 63)));
      cyc();
    end

    // reset between accept and its write cycle
    stop = 0;
    start = 1; in_valid = 0; cyc(); start = 0;
    in_valid = 1;
    setb(0, 6'b100001, 33);
    #1;
    model_edge();
    @(posedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;
    chk_outs();
    chk_rdy();
    repeat (2) begin
      @(posedge Clk);
      #1;
      chk_outs();
    end
    Reset = 1'b1;
    repeat (3) cyc();
    chk("r33_busy", 32'(d0_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
